// File: rtl/taglist_pkg.sv
// Shared taglist entry layout and reader state encoding.
// The entry field positions are also used by the taglist writer.
package taglist_pkg;

    localparam int RSV_MSB   = 31;
    localparam int RSV_LSB   = 28;
    localparam int RSV_W     = RSV_MSB - RSV_LSB + 1;
    localparam int SEQ_MSB   = 27;
    localparam int SEQ_LSB   = 21;
    localparam int SEQ_FW    = SEQ_MSB - SEQ_LSB + 1;
    localparam int FIRST_MSB = 20;
    localparam int FIRST_LSB = 11;
    localparam int FIRST_W   = FIRST_MSB - FIRST_LSB + 1;
    localparam int LAST_MSB  = 10;
    localparam int LAST_LSB  = 1;
    localparam int LAST_W    = LAST_MSB - LAST_LSB + 1;
    localparam int EOR_BIT   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/taglist_reader.sv
// Taglist playback: fetches one entry from the taglist RAM, validates it and
// streams ROM addresses from first to last, with hold and loop control.
module taglist_reader
    import taglist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SEQ_W  = 7
) (
    input  logic              clk_1KHz,
    input  logic              reset,
    input  logic              start,
    input  logic [SEQ_W-1:0]  reqSeq,
    input  logic              hold,
    input  logic              loop,
    output logic [SEQ_W-1:0]  ramAddr,
    input  logic [31:0]       ramData,
    output logic [ADDR_W-1:0] romAddr,
    output logic              romValid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              endOfRom
);

    reader_state_t     state, state_n;
    logic [SEQ_W-1:0]  seq_q, seq_n;
    logic [ADDR_W-1:0] first_q, first_n;
    logic [ADDR_W-1:0] last_q, last_n;
    logic [SEQ_W-1:0]  ramAddr_n;
    logic [ADDR_W-1:0] romAddr_n;
    logic              romValid_n, busy_n, done_n, error_n, endOfRom_n;

    logic [RSV_W-1:0]  ent_rsv;
    logic [SEQ_W-1:0]  ent_seq;
    logic [ADDR_W-1:0] ent_first, ent_last;
    logic              ent_bad;

    always_comb begin
        ent_rsv   = ramData[RSV_MSB:RSV_LSB];
        ent_seq   = SEQ_W'(ramData[SEQ_MSB:SEQ_LSB]);
        ent_first = ADDR_W'(ramData[FIRST_MSB:FIRST_LSB]);
        ent_last  = ADDR_W'(ramData[LAST_MSB:LAST_LSB]);
        ent_bad   = (ent_rsv != '0) || (ent_seq != seq_q) || (ent_first > ent_last);
    end

    always_comb begin
        state_n    = state;
        seq_n      = seq_q;
        first_n    = first_q;
        last_n     = last_q;
        ramAddr_n  = ramAddr;
        romAddr_n  = romAddr;
        romValid_n = romValid;
        busy_n     = busy;
        done_n     = 1'b0;
        error_n    = 1'b0;
        endOfRom_n = endOfRom;

        case (state)
            IDLE: begin
                if (start) begin
                    ramAddr_n = reqSeq;
                    seq_n     = reqSeq;
                    busy_n    = 1'b1;
                    state_n   = FETCH;
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                if (ent_bad) begin
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    first_n    = ent_first;
                    last_n     = ent_last;
                    romAddr_n  = ent_first;
                    romValid_n = 1'b1;
                    endOfRom_n = ramData[EOR_BIT];
                    state_n    = PLAY;
                end
            end
            PLAY: begin
                // hold outranks both wrap and finish
                if (!hold) begin
                    if (romAddr != last_q) begin
                        romAddr_n = romAddr + ADDR_W'(1);
                    end else if (loop) begin
                        romAddr_n = first_q;
                    end else begin
                        romValid_n = 1'b0;
                        done_n     = 1'b1;
                        busy_n     = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_1KHz) begin
        if (reset) begin
            state    <= IDLE;
            seq_q    <= '0;
            first_q  <= '0;
            last_q   <= '0;
            ramAddr  <= '0;
            romAddr  <= '0;
            romValid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            endOfRom <= 1'b0;
        end else begin
            state    <= state_n;
            seq_q    <= seq_n;
            first_q  <= first_n;
            last_q   <= last_n;
            ramAddr  <= ramAddr_n;
            romAddr  <= romAddr_n;
            romValid <= romValid_n;
            busy     <= busy_n;
            done     <= done_n;
            error    <= error_n;
            endOfRom <= endOfRom_n;
        end
    end

endmodule

// File: tb/tb_taglist_reader.sv
// Bench for taglist_reader: directed cases plus randomized entries and hold
// patterns checked against a queue-based model of the expected address stream.
module tb_taglist_reader;

    logic        clk_1KHz = 1'b0;
    logic        reset, start, hold, loop;
    logic [6:0]  reqSeq;
    logic [6:0]  ramAddr;
    logic [31:0] ramData;
    logic [9:0]  romAddr;
    logic        romValid, busy, done, error, endOfRom;

    logic [31:0] mem [128];
    int          checks = 0;
    int          errors = 0;
    logic        eor_exp = 1'b0;

    taglist_reader #(.ADDR_W(10), .SEQ_W(7)) dut (
        .clk_1KHz(clk_1KHz), .reset(reset), .start(start), .reqSeq(reqSeq),
        .hold(hold), .loop(loop), .ramAddr(ramAddr), .ramData(ramData),
        .romAddr(romAddr), .romValid(romValid), .busy(busy), .done(done),
        .error(error), .endOfRom(endOfRom)
    );

    always #5 clk_1KHz = ~clk_1KHz;

    // synchronous-read taglist RAM
    always @(posedge clk_1KHz) ramData <= mem[ramAddr];

    function automatic logic [31:0] mk(input logic [3:0] r, input logic [6:0] s,
                                       input logic [9:0] f, input logic [9:0] l,
                                       input logic e);
        return {r, s, f, l, e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive start at a negedge, then observe the FETCH and LOAD cycles.
    task automatic kick(input logic [6:0] s);
        start = 1'b1; reqSeq = s;
        @(negedge clk_1KHz);
        start = 1'b0;
        chk("ramAddr_after_E0", 32'(ramAddr), 32'(s));
        chk("busy_after_E0", 32'(busy), 1);
        chk("done_clear_after_E0", 32'(done), 0);
        chk("error_clear_after_E0", 32'(error), 0);
        @(negedge clk_1KHz);
        chk("busy_in_LOAD", 32'(busy), 1);
        chk("romValid_in_LOAD", 32'(romValid), 0);
        @(negedge clk_1KHz);
    endtask

    // Ends at the negedge where done/error is visible, so a following call
    // issues its start in the done/error cycle.
    task automatic play_check(input logic [6:0] s, input int hold_pct);
        logic [31:0] e;
        logic [9:0]  f, l, exp_addr[$];
        bit          ok, h;
        int          cyc;
        e = mem[s];
        f = e[20:11];
        l = e[10:1];
        ok = (e[31:28] == 4'd0) && (e[27:21] == s) && (f <= l);
        kick(s);
        if (!ok) begin
            chk("error_pulse", 32'(error), 1);
            chk("busy_low_on_error", 32'(busy), 0);
            chk("romValid_low_on_error", 32'(romValid), 0);
            chk("endOfRom_kept_on_error", 32'(endOfRom), 32'(eor_exp));
            return;
        end
        eor_exp = e[0];
        // expected stream: every address first..last once, held addresses repeated
        for (int a = int'(f); a <= int'(l); a++) exp_addr.push_back(10'(a));
        cyc = 0;
        while (exp_addr.size() > 0 && cyc < 1000) begin
            chk("romAddr_stream", 32'(romAddr), 32'(exp_addr[0]));
            chk("romValid_in_PLAY", 32'(romValid), 1);
            chk("done_low_in_PLAY", 32'(done), 0);
            chk("endOfRom_value", 32'(endOfRom), 32'(eor_exp));
            h = ($urandom_range(99) < hold_pct);
            hold = h;
            @(negedge clk_1KHz);
            if (!h) void'(exp_addr.pop_front());
            cyc++;
        end
        hold = 1'b0;
        chk("stream_within_budget", 32'(exp_addr.size()), 0);
        chk("done_pulse", 32'(done), 1);
        chk("romValid_low_after_last", 32'(romValid), 0);
        chk("busy_low_with_done", 32'(busy), 0);
    endtask

    initial begin
        logic [9:0] exp_loop [6];
        logic [6:0] s;
        logic [9:0] f, l;
        logic [3:0] r;
        logic [6:0] sf;
        int         kind;

        for (int i = 0; i < 128; i++) mem[i] = 32'hF000_0000;
        reset = 1'b1; start = 1'b0; hold = 1'b0; loop = 1'b0; reqSeq = '0;
        @(negedge clk_1KHz);
        @(negedge clk_1KHz);
        chk("rst_ramAddr", 32'(ramAddr), 0);
        chk("rst_romAddr", 32'(romAddr), 0);
        chk("rst_romValid", 32'(romValid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_endOfRom", 32'(endOfRom), 0);
        reset = 1'b0;
        @(negedge clk_1KHz);

        // normal, single-address, and three kinds of reject, back to back
        mem[3] = mk(4'h0, 7'd3, 10'h010, 10'h013, 1'b0);
        play_check(7'd3, 0);
        mem[0] = mk(4'h0, 7'd0, 10'h3FF, 10'h3FF, 1'b1);
        play_check(7'd0, 0);
        mem[5] = mk(4'h0, 7'd4, 10'h001, 10'h002, 1'b0);
        play_check(7'd5, 0);
        mem[6] = mk(4'h0, 7'd6, 10'h020, 10'h01F, 1'b0);
        play_check(7'd6, 0);
        mem[8] = mk(4'h1, 7'd8, 10'h001, 10'h002, 1'b0);
        play_check(7'd8, 0);

        // randomized entries and hold patterns
        for (int n = 0; n < 30; n++) begin
            s = 7'($urandom_range(127));
            f = 10'($urandom_range(1023));
            l = (int'(f) + 11 > 1023) ? 10'h3FF : f + 10'($urandom_range(11));
            r = 4'h0;
            sf = s;
            kind = $urandom_range(5);
            if (kind == 0) sf = s ^ 7'($urandom_range(127, 1));
            if (kind == 1) r = 4'($urandom_range(15, 1));
            if (kind == 2) begin
                if (f == 10'h0) f = 10'h1;
                l = f - 10'($urandom_range(int'(f), 1));
            end
            mem[s] = mk(r, sf, f, l, 1'($urandom_range(1)));
            play_check(s, 30);
        end
        @(negedge clk_1KHz);
        chk("done_one_cycle", 32'(done), 0);
        chk("error_idle_low", 32'(error), 0);
        chk("busy_idle_low", 32'(busy), 0);

        // loop: 10 11 12 10 11, drop loop at 11, then 12 and done
        mem[7] = mk(4'h0, 7'd7, 10'h010, 10'h012, 1'b0);
        exp_loop = '{10'h010, 10'h011, 10'h012, 10'h010, 10'h011, 10'h012};
        loop = 1'b1;
        kick(7'd7);
        for (int i = 0; i < 6; i++) begin
            chk("loop_romAddr", 32'(romAddr), 32'(exp_loop[i]));
            chk("loop_romValid", 32'(romValid), 1);
            if (i == 4) loop = 1'b0;
            @(negedge clk_1KHz);
        end
        chk("loop_done", 32'(done), 1);
        chk("loop_romValid_end", 32'(romValid), 0);
        @(negedge clk_1KHz);

        // hold at 0x011 for three edges, with a start during PLAY ignored
        kick(7'd3);
        chk("hold_first", 32'(romAddr), 32'h010);
        start = 1'b1; reqSeq = 7'd9;
        @(negedge clk_1KHz);
        start = 1'b0;
        chk("start_in_play_ignored", 32'(ramAddr), 3);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_romAddr", 32'(romAddr), 32'h011);
            if (i == 3) hold = 1'b0;
            @(negedge clk_1KHz);
        end
        chk("after_hold_12", 32'(romAddr), 32'h012);
        @(negedge clk_1KHz);
        chk("after_hold_13", 32'(romAddr), 32'h013);
        chk("ramAddr_still_3", 32'(ramAddr), 3);
        @(negedge clk_1KHz);
        chk("hold_done", 32'(done), 1);
        @(negedge clk_1KHz);

        // reset mid-PLAY
        mem[0] = mk(4'h0, 7'd0, 10'h100, 10'h108, 1'b1);
        kick(7'd0);
        @(negedge clk_1KHz);
        chk("pre_reset_romAddr", 32'(romAddr), 32'h101);
        chk("pre_reset_endOfRom", 32'(endOfRom), 1);
        reset = 1'b1;
        @(negedge clk_1KHz);
        reset = 1'b0;
        chk("mid_rst_ramAddr", 32'(ramAddr), 0);
        chk("mid_rst_romAddr", 32'(romAddr), 0);
        chk("mid_rst_romValid", 32'(romValid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_error", 32'(error), 0);
        chk("mid_rst_endOfRom", 32'(endOfRom), 0);
        @(negedge clk_1KHz);
        chk("post_rst_no_done", 32'(done), 0);
        chk("post_rst_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
